// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, fetch-buffer entry layout,
// NOP constant and the base opcode map.
package rv32i_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Words outside the 32-bit encoding space are turned into a flagged NOP.
  function automatic fetch_entry_t make_entry(input logic [31:0] pc, input logic [31:0] rdata);
    fetch_entry_t e;
    e.pc = pc;
    if (rdata[1:0] != 2'b11) begin
      e.inst    = NOP_INST;
      e.illegal = 1'b1;
    end else begin
      e.inst    = rdata;
      e.illegal = 1'b0;
    end
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched instructions; flush empties it and wins
// over any push or pop in the same cycle.
module fetch_buffer
  import rv32i_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem_r [2];
  logic               rd_ptr_r;
  logic               wr_ptr_r;
  logic [1:0]         count_r;
  logic               do_pop_s;
  logic               do_push_s;

  // Qualify requests so an entry is never overwritten or popped from empty.
  always_comb begin
    do_pop_s  = pop & (count_r != 2'd0);
    do_push_s = push & ((count_r != 2'd2) | do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem_r[i] <= '0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) rd_ptr_r <= ~rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem access, redirect flush/refetch,
// and a two-entry buffer feeding decode.
module inst_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_illegal_o
);

  localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

  fetch_state_e       state_r;
  fetch_state_e       state_s;
  logic [31:0]        pc_r;
  logic [31:0]        tag_r;
  logic [1:0]         count_s;
  logic [ENTRY_W-1:0] head_s;
  logic               req_s;
  logic               push_s;
  logic               pop_s;
  fetch_entry_t       head_entry_s;
  fetch_entry_t       push_entry_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= FS_REQ;
    else          state_r <= state_s;
  end

  // Next state; a response landing with a redirect still closes the access.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FS_REQ: begin
        if (req_s && imem_gnt_i) state_s = FS_WAIT;
        else                     state_s = FS_REQ;
      end
      FS_WAIT: begin
        if (imem_rvalid_i)   state_s = FS_REQ;
        else if (redirect_i) state_s = FS_DROP;
        else                 state_s = FS_WAIT;
      end
      FS_DROP: begin
        if (imem_rvalid_i) state_s = FS_REQ;
        else               state_s = FS_DROP;
      end
      default: state_s = FS_REQ;
    endcase
  end

  // Outputs and buffer controls.
  always_comb begin
    head_entry_s = fetch_entry_t'(head_s);
    req_s        = reset_n & (state_r == FS_REQ) & (count_s < FULL_COUNT) & ~redirect_i;
    imem_req_o   = req_s;
    imem_addr_o  = pc_r;
    if_valid_o   = (count_s != 2'd0) & ~redirect_i;
    if_inst_o    = head_entry_s.inst;
    if_pc_o      = head_entry_s.pc;
    if_illegal_o = head_entry_s.illegal;
    pop_s        = if_valid_o & ~stall_i;
    push_s       = (state_r == FS_WAIT) & imem_rvalid_i & ~redirect_i;
    push_entry_s = make_entry(tag_r, imem_rdata_i);
  end

  // Fetch address and tag of the outstanding access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r  <= RESET_PC;
      tag_r <= 32'h0000_0000;
    end else if (redirect_i) begin
      pc_r  <= {redirect_pc_i[31:2], 2'b00};
      tag_r <= tag_r;
    end else if (req_s && imem_gnt_i) begin
      pc_r  <= pc_r + 32'd4;
      tag_r <= pc_r;
    end else begin
      pc_r  <= pc_r;
      tag_r <= tag_r;
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (redirect_i),
    .head       (head_s),
    .count      (count_s)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a simple imem responder plus per-scenario
// tasks comparing the popped instruction stream to hand-computed values.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        if_illegal_o;

  typedef struct {
    logic        ill;
    logic [31:0] pc;
    logic [31:0] inst;
    int          cyc;
  } pop_t;

  pop_t        popped[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        pend = 1'b0;
  logic        auto_resp = 1'b1;
  logic [31:0] mem_word = 32'h0050_0093;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o),
    .if_illegal_o  (if_illegal_o)
  );

  // One clock: log any pop, note a granted request, answer it next cycle.
  task automatic tick();
    pop_t p;
    #1;
    if (if_valid_o && !stall_i) begin
      p.ill = if_illegal_o; p.pc = if_pc_o; p.inst = if_inst_o; p.cyc = cyc;
      popped.push_back(p);
    end
    pend = imem_req_o & imem_gnt_i;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_resp) begin
      imem_rvalid_i = pend;
      imem_rdata_i  = pend ? mem_word : 32'h0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    pend = 1'b0; auto_resp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    popped.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    @(posedge clk); #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", if_inst_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc_o); end
    checks++; if (if_illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", if_illegal_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr_o); end
  endtask

  task automatic test_basic();
    do_reset();
    #1;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL basic_first_req: got %b want 1", imem_req_o); end
    repeat (10) tick();
    checks++; if (popped.size() < 3) begin errors++; $display("FAIL basic_count: got %0d want >=3", popped.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (popped[i].pc !== 32'(4 * i) || popped[i].inst !== 32'h0050_0093 || popped[i].ill !== 1'b0) begin
        errors++;
        $display("FAIL basic_pop%0d: got pc=%h inst=%h ill=%b want pc=%h inst=00500093 ill=0",
                 i, popped[i].pc, popped[i].inst, popped[i].ill, 32'(4 * i));
      end
    end
    // Response in tick 2 becomes visible on the next cycle (tick 3 log, cyc 2).
    checks++; if (popped[0].cyc !== 2) begin errors++; $display("FAIL basic_latency: got cyc %0d want 2", popped[0].cyc); end
  endtask

  task automatic test_stall();
    do_reset();
    stall_i = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_full_req%0d: got %b want 0", i, imem_req_o); end
      tick();
    end
    #1;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) begin errors++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0", if_valid_o, if_pc_o); end
    stall_i = 1'b0;
    repeat (10) tick();
    checks++; if (popped.size() < 4) begin errors++; $display("FAIL stall_count: got %0d want >=4", popped.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (popped[i].pc !== 32'(4 * i)) begin errors++; $display("FAIL stall_order%0d: got %h want %h", i, popped[i].pc, 32'(4 * i)); end
    end
    checks++; if (popped[1].cyc !== popped[0].cyc + 1) begin errors++; $display("FAIL stall_two_buffered: got gap %0d want 1", popped[1].cyc - popped[0].cyc); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    auto_resp = 1'b0;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    checks++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin errors++; $display("FAIL redir_wait_mask: got req=%b v=%b want 0 0", imem_req_o, if_valid_o); end
    tick();
    redirect_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL redir_drop_req: got %b want 0", imem_req_o); end
    tick();
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; auto_resp = 1'b1;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL redir_dropped: got v=%b want 0", if_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL redir_refetch: got req=%b addr=%h want 1 00000100", imem_req_o, imem_addr_o); end
    repeat (6) tick();
    checks++; if (popped.size() < 2 || popped[0].pc !== 32'h100 || popped[1].pc !== 32'h104) begin
      errors++; $display("FAIL redir_stream: got n=%0d pc0=%h pc1=%h want 00000100 00000104", popped.size(), popped[0].pc, popped[1].pc);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    mem_word = 32'hFFFF_FFFC;
    repeat (4) tick();
    mem_word = 32'h0050_0093;
    checks++; if (popped.size() < 1 || popped[0].inst !== 32'h0000_0013 || popped[0].ill !== 1'b1 || popped[0].pc !== 32'h0) begin
      errors++; $display("FAIL illegal_nop: got inst=%h ill=%b pc=%h want 00000013 1 0", popped[0].inst, popped[0].ill, popped[0].pc);
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    do_reset();
    stall_i = 1'b1;
    repeat (3) tick();
    stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    #1;
    checks++; if (if_valid_o !== 1'b0 || imem_rvalid_i !== 1'b1) begin errors++; $display("FAIL flush_setup: got v=%b rvalid=%b want 0 1", if_valid_o, imem_rvalid_i); end
    tick();
    redirect_i = 1'b0;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got v=%b want 0", if_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++; $display("FAIL flush_next_addr: got req=%b addr=%h want 1 00000200", imem_req_o, imem_addr_o); end
    repeat (4) tick();
    checks++; if (popped.size() < 1 || popped[0].pc !== 32'h200) begin errors++; $display("FAIL flush_stream: got n=%0d pc=%h want 00000200", popped.size(), popped[0].pc); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    stall_i = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    checks++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0 || if_illegal_o !== 1'b0) begin
      errors++; $display("FAIL rst_wait_outputs: got v=%b pc=%h inst=%h ill=%b want all 0", if_valid_o, if_pc_o, if_inst_o, if_illegal_o);
    end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_wait_req: got %b want 0", imem_req_o); end
    @(posedge clk); #1;
    reset_n = 1'b1; stall_i = 1'b0; pend = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hFFFF_FFFC;
    popped.delete();
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_wait_first_req: got req=%b addr=%h want 1 0", imem_req_o, imem_addr_o); end
    repeat (6) tick();
    checks++; if (popped.size() < 2 || popped[0].pc !== 32'h0 || popped[0].ill !== 1'b0 || popped[1].pc !== 32'h4) begin
      errors++; $display("FAIL rst_wait_stream: got n=%0d pc0=%h ill0=%b pc1=%h want 0 0 4", popped.size(), popped[0].pc, popped[0].ill, popped[1].pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_illegal();
    test_redirect_rvalid_pop();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
